hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// - Read-after-write interlock for the in-order pipeline; sits beside the decode stage and drives its stall input.
// - Tracks destination registers of instructions issued by decode but not yet written back, in issue order.
// - Stalls decode while the instruction at its input reads a pending register, or while the tracker is full.
// PARAMETERS
// - DEPTH  4  max in-flight register-writing instructions; power of 2, >= 2
// - AW     2  log2(DEPTH); pointer width
// PORTS
// - clk         in   1   clock, all state on rising edge
// - rst         in   1   synchronous, active-high reset
// - instr       in   32  instruction at the decode input
// - valid       in   1   instr is present at the decode input
// - issue       in   1   decode accepts instr this cycle (valid && ready && !jmp)
// - kill        in   1   jmp flush: youngest tracked entry was killed in decode's output register
// - retire      in   1   writeback writes a register this cycle
// - retire_reg  in   5   register being written back
// - stall       out  1   to decode stall input
// - busy        out  1   at least one entry tracked
// - full        out  1   DEPTH entries tracked
// - count       out  AW+1 entries tracked
// - err         out  1   sticky protocol error flag
// BEHAVIOUR
// - Reset: count=0, rd/wr pointers=0, all entry valid bits=0, err=0; busy=full=stall=0.
// - Operand use from instr[6:0]: rs1 read by all opcodes except LUI, AUIPC, JAL;
//   rs2 read only by OP, STORE, BRANCH. Reads of x0 never hazard.
// - Dest write: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR write rd=instr[11:7]; rd=x0 counts as no write.
// - stall = valid && (hit_rs1 || hit_rs2 || full); combinational, zero latency; hit = match to any valid entry.
// - Retire of a matching register in the same cycle does NOT clear the hit: stall holds that cycle, released next
//   cycle (register file updates on the edge; decode reads stale value otherwise).
// - Push: issue && !kill && instr writes rd!=0 && !full -> entry[wr]=rd, wr+1 (mod DEPTH).
//   issue while full is a protocol error: err<=1, nothing pushed.
// - issue && kill same cycle: issue ignored (decode does not load on jmp).
// - Retire pop: retire && busy -> head entry must equal retire_reg; pop head, rd+1 (mod DEPTH).
//   Mismatch -> err<=1, head still popped. retire while empty -> err<=1, ignored.
// - retire with retire_reg=x0 is ignored (no pop, no error).
// - Kill pop: kill && busy -> youngest entry (wr-1) invalidated, wr-1. kill while empty: no effect, no error.
// - retire && kill with count==1: single entry removed once, count->0, no error; with count>=2: both pops, count-2.
// - count updated as +push -retire_pop -kill_pop; pointers wrap modulo DEPTH; never exceeds DEPTH, never negative.
// - err only cleared by rst. rst mid-operation discards all tracked entries immediately (next cycle empty).
// CONFIGURATION
// - Macro SCOREBOARD_STATS_EN.
// - Defined: extra output stall_cycles [31:0]; +1 every cycle stall==1, saturates at 32'hFFFFFFFF, reset to 0.
// - Undefined: port and counter absent; no other behaviour changes.
// STRUCTURE
// - Shared package cpu.vh: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR).
// - One sub-module: dest_fifo (DEPTH x 5-bit register-number FIFO with per-entry valid, push/pop-head/pop-tail,
//   exposes all entries for parallel compare). Top: operand decode, compare, stall, err, stats.
// TESTING
// - Reset, valid with ADDI x1,x0,1 (0x00100093), empty -> stall=0; issue -> count=1, busy=1.
// - Pending x1; valid ADD x2,x1,x1 -> stall=1; retire x1 same cycle -> stall still 1; next cycle stall=0, count=0.
// - Pending x5; valid LUI x5 / JAL x5 -> stall=0 (no rs use); valid SW x5,0(x6) -> stall=1 (rs2 hit).
// - Issue 4 writers x1..x4 -> full=1, stall=1 on any valid; retire x1 -> full=0; retire x9 next -> err=1, head popped.
// - Issue x7 then x8, kill -> count=1, x8 no longer hazards; retire+kill with count==1 -> count=0, err=0.
// - rst asserted with count=3 -> next cycle count=0, busy=0, err=0; stall_cycles (SCOREBOARD_STATS_EN) =0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode constants and operand-usage decode for the RAW hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } operand_use_t;

    function automatic operand_use_t decode_use(input logic [6:0] opcode);
        operand_use_t u;
        u.rs1 = !(opcode == LUI || opcode == AUIPC || opcode == JAL);
        u.rs2 = (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);
        u.rd  = (opcode == OP) || (opcode == OP_IMM) || (opcode == LOAD) || (opcode == LUI) ||
                (opcode == AUIPC) || (opcode == JAL) || (opcode == JALR);
        return u;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback-side signal bundle of the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int AW = 2
);
    // Decode presents instr with valid; it asserts issue only when it loads instr
    // (valid && !stall && !jmp). stall is the scoreboard's sole back-pressure.
    logic [31:0] instr;
    logic        valid;
    logic        issue;
    logic        kill;
    logic        retire;
    logic [4:0]  retire_reg;
    logic        stall;
    logic        busy;
    logic        full;
    logic [AW:0] count;
    logic        err;

    modport master (
        output instr, valid, issue, kill, retire, retire_reg,
        input  stall, busy, full, count, err
    );

    modport slave (
        input  instr, valid, issue, kill, retire, retire_reg,
        output stall, busy, full, count, err
    );
endinterface

// File: rtl/hazard_scoreboard_dest_fifo.sv
// In-order FIFO of pending destination registers: push at tail, pop at head or tail,
// every entry exposed with its valid bit for parallel compare.
module dest_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [4:0]            push_reg,
    input  logic                  pop_head,
    input  logic                  pop_tail,
    output logic [4:0]            head_reg,
    output logic [DEPTH-1:0][4:0] entry_reg,
    output logic [DEPTH-1:0]      entry_vld,
    output logic [AW:0]           count
);
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] tail_ptr;

    assign tail_ptr = wr_ptr - AW'(1);
    assign head_reg = entry_reg[rd_ptr];

    // Caller guarantees push never coincides with pop_tail and never targets a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            entry_vld <= '0;
            count     <= '0;
        end else begin
            if (push)     entry_vld[wr_ptr]   <= 1'b1;
            if (pop_head) entry_vld[rd_ptr]   <= 1'b0;
            if (pop_tail) entry_vld[tail_ptr] <= 1'b0;
            rd_ptr <= rd_ptr + AW'(pop_head);
            wr_ptr <= wr_ptr + AW'(push) - AW'(pop_tail);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop_head) - (AW+1)'(pop_tail);
        end
    end

    always_ff @(posedge clk) begin
        if (push) entry_reg[wr_ptr] <= push_reg;
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Read-after-write interlock beside decode: tracks in-flight destination registers and stalls decode.
// Optional stall-cycle counter output enabled by defining SCOREBOARD_STATS_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave sb
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);
    logic [6:0]            opcode;
    reg_idx_t              rs1, rs2, rd;
    operand_use_t          op_use;
    logic [DEPTH-1:0][4:0] entry_reg;
    logic [DEPTH-1:0]      entry_vld;
    reg_idx_t              head_reg;
    logic [AW:0]           count;
    logic                  hit_rs1, hit_rs2, busy, full;
    logic                  accept, push, ret_act, pop_head, pop_tail;
    logic                  issue_err, ret_err, err_q;
    logic                  unused_instr_bits;

    assign opcode            = sb.instr[6:0];
    assign rd                = sb.instr[11:7];
    assign rs1               = sb.instr[19:15];
    assign rs2               = sb.instr[24:20];
    assign op_use            = decode_use(opcode);
    assign unused_instr_bits = ^{sb.instr[31:25], sb.instr[14:12]};

    // Same-cycle retire does not mask a hit: the register file only updates on the edge.
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && entry_reg[i] == rs1) hit_rs1 = 1'b1;
            if (entry_vld[i] && entry_reg[i] == rs2) hit_rs2 = 1'b1;
        end
        hit_rs1 = hit_rs1 && op_use.rs1 && (rs1 != 5'd0);
        hit_rs2 = hit_rs2 && op_use.rs2 && (rs2 != 5'd0);
    end

    assign busy      = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign accept    = sb.issue && !sb.kill;
    assign push      = accept && op_use.rd && (rd != 5'd0) && !full;
    assign issue_err = accept && full;
    assign ret_act   = sb.retire && (sb.retire_reg != 5'd0);
    assign pop_head  = ret_act && busy;
    assign ret_err   = ret_act && (!busy || head_reg != sb.retire_reg);
    // With a single entry, retire and kill both name it: remove it only once.
    assign pop_tail  = sb.kill && busy && !(pop_head && count == (AW+1)'(1));

    dest_fifo #(.DEPTH(DEPTH), .AW(AW)) u_dest_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_reg  (rd),
        .pop_head  (pop_head),
        .pop_tail  (pop_tail),
        .head_reg  (head_reg),
        .entry_reg (entry_reg),
        .entry_vld (entry_vld),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | issue_err | ret_err;
    end

    assign sb.stall = sb.valid && (hit_rs1 || hit_rs2 || full);
    assign sb.busy  = busy;
    assign sb.full  = full;
    assign sb.count = count;
    assign sb.err   = err_q;

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                                       stall_cycles <= '0;
        else if (sb.stall && stall_cycles != 32'hFFFFFFFF) stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// against a queue-based model of pending destination registers.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(AW)) sb ();
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    hazard_scoreboard #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    logic [4:0]  exp_q[$];
    bit          m_err;
    logic [31:0] m_sc;
    int          n_cmp, n_bad;
    logic [6:0]  ops[10] = '{OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, 7'b1110011};

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] r1,
                                       input logic [4:0] r2);
        return {7'b0, r2, r1, 3'b0, rd, op};
    endfunction

    function automatic bit writes(input logic [6:0] op);
        return op == OP || op == OP_IMM || op == LOAD || op == LUI || op == AUIPC || op == JAL || op == JALR;
    endfunction

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (exp_q[i]) if (exp_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_stall();
        logic [6:0] op;
        op = sb.instr[6:0];
        if (!sb.valid) return 1'b0;
        if (exp_q.size() == DEPTH) return 1'b1;
        if (op != LUI && op != AUIPC && op != JAL && pending(sb.instr[19:15])) return 1'b1;
        if ((op == OP || op == STORE || op == BRANCH) && pending(sb.instr[24:20])) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] ins, input logic iss, input logic k,
                          input logic r, input logic [4:0] rr);
        sb.valid = v; sb.instr = ins; sb.issue = iss; sb.kill = k; sb.retire = r; sb.retire_reg = rr;
    endtask

    // Advance one clock, applying the current inputs to the model first.
    task automatic tick();
        bit s, did_ret;
        int n;
        logic [6:0] op;
        logic [4:0] rd;
        s = ref_stall(); n = exp_q.size(); op = sb.instr[6:0]; rd = sb.instr[11:7]; did_ret = 1'b0;
        if (rst) begin
            exp_q.delete(); m_err = 1'b0; m_sc = '0;
        end else begin
            if (s && m_sc != 32'hFFFFFFFF) m_sc++;
            if (sb.retire && sb.retire_reg != 5'd0) begin
                if (n == 0) m_err = 1'b1;
                else begin
                    if (exp_q[0] != sb.retire_reg) m_err = 1'b1;
                    void'(exp_q.pop_front());
                    did_ret = 1'b1;
                end
            end
            if (sb.kill && (n >= 2 || (n == 1 && !did_ret))) void'(exp_q.pop_back());
            if (sb.issue && !sb.kill) begin
                if (n == DEPTH) m_err = 1'b1;
                else if (writes(op) && rd != 5'd0) exp_q.push_back(rd);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        set_in(0, 32'd0, 0, 0, 0, 5'd0);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_cmp++; if (sb.count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", sb.count); end
        n_cmp++; if (sb.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", sb.busy); end
        n_cmp++; if (sb.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", sb.full); end
        n_cmp++; if (sb.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", sb.err); end
        n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", sb.stall); end
`ifdef SCOREBOARD_STATS_EN
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stats: got %0d want 0", stall_cycles); end
`endif
    endtask

    task automatic test_basic_issue();
        set_in(1, 32'h00100093, 0, 0, 0, 5'd0); #1;
        n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL addi_empty_stall: got %b want 0", sb.stall); end
        sb.issue = 1'b1; tick();
        n_cmp++; if (sb.count !== 3'd1) begin n_bad++; $display("FAIL addi_count: got %0d want 1", sb.count); end
        n_cmp++; if (sb.busy !== 1'b1) begin n_bad++; $display("FAIL addi_busy: got %b want 1", sb.busy); end
    endtask

    task automatic test_retire_same_cycle();
        set_in(1, 32'h00108133, 0, 0, 1, 5'd1); #1;
        n_cmp++; if (sb.stall !== 1'b1) begin n_bad++; $display("FAIL same_cycle_retire_stall: got %b want 1", sb.stall); end
        tick();
        set_in(1, 32'h00108133, 0, 0, 0, 5'd0); #1;
        n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL after_retire_stall: got %b want 0", sb.stall); end
        n_cmp++; if (sb.count !== 3'd0) begin n_bad++; $display("FAIL after_retire_count: got %0d want 0", sb.count); end
    endtask

    task automatic test_operand_use();
        set_in(1, mk(OP_IMM, 5'd5, 5'd0, 5'd0), 1, 0, 0, 5'd0); tick();
        set_in(1, mk(LUI, 5'd5, 5'd5, 5'd5), 0, 0, 0, 5'd0); #1;
        n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL lui_stall: got %b want 0", sb.stall); end
        sb.instr = mk(JAL, 5'd5, 5'd5, 5'd5); #1;
        n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL jal_stall: got %b want 0", sb.stall); end
        sb.instr = mk(STORE, 5'd0, 5'd6, 5'd5); #1;
        n_cmp++; if (sb.stall !== 1'b1) begin n_bad++; $display("FAIL sw_rs2_stall: got %b want 1", sb.stall); end
        sb.instr = mk(OP_IMM, 5'd9, 5'd6, 5'd5); #1;
        n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL addi_rs2field_stall: got %b want 0", sb.stall); end
        set_in(0, 32'd0, 0, 0, 1, 5'd5); tick();
    endtask

    task automatic test_full_err();
        for (int r = 1; r <= 4; r++) begin
            set_in(1, mk(OP_IMM, 5'(r), 5'd0, 5'd0), 1, 0, 0, 5'd0); tick();
        end
        n_cmp++; if (sb.full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b want 1", sb.full); end
        n_cmp++; if (sb.count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", sb.count); end
        set_in(1, mk(OP_IMM, 5'd10, 5'd0, 5'd0), 0, 0, 0, 5'd0); #1;
        n_cmp++; if (sb.stall !== 1'b1) begin n_bad++; $display("FAIL full_stall: got %b want 1", sb.stall); end
        set_in(0, 32'd0, 0, 0, 1, 5'd1); tick();
        n_cmp++; if (sb.full !== 1'b0) begin n_bad++; $display("FAIL unfull_flag: got %b want 0", sb.full); end
        n_cmp++; if (sb.err !== 1'b0) begin n_bad++; $display("FAIL good_retire_err: got %b want 0", sb.err); end
        set_in(0, 32'd0, 0, 0, 1, 5'd9); tick();
        n_cmp++; if (sb.err !== 1'b1) begin n_bad++; $display("FAIL mismatch_err: got %b want 1", sb.err); end
        n_cmp++; if (sb.count !== 3'd2) begin n_bad++; $display("FAIL mismatch_pop_count: got %0d want 2", sb.count); end
        set_in(1, mk(OP, 5'd11, 5'd2, 5'd0), 0, 0, 0, 5'd0); #1;
        n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL popped_x2_stall: got %b want 0", sb.stall); end
    endtask

    task automatic test_kill();
        set_in(0, 32'd0, 0, 0, 0, 5'd0); rst = 1'b1; tick(); rst = 1'b0;
        set_in(1, mk(OP_IMM, 5'd7, 5'd0, 5'd0), 1, 0, 0, 5'd0); tick();
        set_in(1, mk(OP_IMM, 5'd8, 5'd0, 5'd0), 1, 0, 0, 5'd0); tick();
        set_in(0, 32'd0, 0, 1, 0, 5'd0); tick();
        n_cmp++; if (sb.count !== 3'd1) begin n_bad++; $display("FAIL kill_count: got %0d want 1", sb.count); end
        set_in(1, mk(OP, 5'd12, 5'd8, 5'd8), 0, 0, 0, 5'd0); #1;
        n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL killed_x8_stall: got %b want 0", sb.stall); end
        sb.instr = mk(OP, 5'd12, 5'd7, 5'd0); #1;
        n_cmp++; if (sb.stall !== 1'b1) begin n_bad++; $display("FAIL kept_x7_stall: got %b want 1", sb.stall); end
        set_in(0, 32'd0, 0, 1, 1, 5'd7); tick();
        n_cmp++; if (sb.count !== 3'd0) begin n_bad++; $display("FAIL retire_kill_count: got %0d want 0", sb.count); end
        n_cmp++; if (sb.err !== 1'b0) begin n_bad++; $display("FAIL retire_kill_err: got %b want 0", sb.err); end
    endtask

    task automatic test_rst_mid();
        for (int r = 1; r <= 3; r++) begin
            set_in(1, mk(LOAD, 5'(r), 5'd0, 5'd0), 1, 0, 0, 5'd0); tick();
        end
        set_in(1, mk(OP, 5'd4, 5'd1, 5'd2), 0, 0, 0, 5'd0); tick();
        n_cmp++; if (sb.count !== 3'd3) begin n_bad++; $display("FAIL pre_rst_count: got %0d want 3", sb.count); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (sb.count !== 3'd0) begin n_bad++; $display("FAIL rst_mid_count: got %0d want 0", sb.count); end
        n_cmp++; if (sb.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", sb.busy); end
        n_cmp++; if (sb.err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_err: got %b want 0", sb.err); end
`ifdef SCOREBOARD_STATS_EN
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_mid_stats: got %0d want 0", stall_cycles); end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            bit v, s;
            logic [6:0] op;
            op = ops[$urandom_range(0, 9)];
            v  = ($urandom_range(0, 9) < 8);
            set_in(v, mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))), 0, 0, 0, 5'd0);
            sb.instr[31:25] = 7'($urandom_range(0, 127));
            s = ref_stall();
            sb.issue = v && (!s || $urandom_range(0, 49) == 0);
            sb.kill  = ($urandom_range(0, 15) == 0);
            if (exp_q.size() > 0 && $urandom_range(0, 9) < 4) begin
                sb.retire = 1'b1;
                sb.retire_reg = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 7)) : exp_q[0];
            end else if ($urandom_range(0, 19) == 0) begin
                sb.retire = 1'b1; sb.retire_reg = 5'($urandom_range(0, 7));
            end
            rst = ($urandom_range(0, 59) == 0);
            #1;
            n_cmp++; if (sb.stall !== s) begin n_bad++; $display("FAIL rand_stall c=%0d: got %b want %b", c, sb.stall, s); end
            tick();
            rst = 1'b0;
            n_cmp++; if (sb.count !== (AW+1)'(exp_q.size())) begin n_bad++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, sb.count, exp_q.size()); end
            n_cmp++; if (sb.busy !== (exp_q.size() != 0)) begin n_bad++; $display("FAIL rand_busy c=%0d: got %b", c, sb.busy); end
            n_cmp++; if (sb.full !== (exp_q.size() == DEPTH)) begin n_bad++; $display("FAIL rand_full c=%0d: got %b", c, sb.full); end
            n_cmp++; if (sb.err !== m_err) begin n_bad++; $display("FAIL rand_err c=%0d: got %b want %b", c, sb.err, m_err); end
`ifdef SCOREBOARD_STATS_EN
            n_cmp++; if (stall_cycles !== m_sc) begin n_bad++; $display("FAIL rand_stats c=%0d: got %0d want %0d", c, stall_cycles, m_sc); end
`endif
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; m_err = 1'b0; m_sc = '0;
        test_reset();
        test_basic_issue();
        test_retire_same_cycle();
        test_operand_use();
        test_full_err();
        test_kill();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
